data_bus_arbiter: RTL and testbench

- Two-master arbiter for the single RAM data port (port 2: a2/di2/do2/m2/we2).
- Master 0 is the CPU data interface; master 1 is an auxiliary master (DMA/debug loader).
- Grants at most one transfer per cycle using round-robin priority. Master 1 may lock the port for bounded bursts.
- Stalls the losing master through a per-master ack.

---
 rtl/data_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared RAM data port, with a bounded lock for master 1.
// Optional grant/stall statistics counters are built in when ARB_STATS_EN is defined.
module data_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0Req,
    input  logic                m0We,
    input  logic [ADDR_W-1:0]   m0Addr,
    input  logic [DATA_W-1:0]   m0WData,
    input  logic [DATA_W/8-1:0] m0Mask,
    output logic [DATA_W-1:0]   m0RData,
    output logic                m0Ack,
    input  logic                m1Req,
    input  logic                m1We,
    input  logic [ADDR_W-1:0]   m1Addr,
    input  logic [DATA_W-1:0]   m1WData,
    input  logic [DATA_W/8-1:0] m1Mask,
    output logic [DATA_W-1:0]   m1RData,
    output logic                m1Ack,
    input  logic                m1Lock,
    output logic [ADDR_W-1:0]   ramAddr,
    output logic [DATA_W-1:0]   ramWData,
    output logic [DATA_W/8-1:0] ramMask,
    output logic                ramWe,
    input  logic [DATA_W-1:0]   ramRData
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         statGnt0,
    output logic [31:0]         statGnt1,
    output logic [31:0]         statStall0
`endif
);

    // state | meaning
    // IDLE  | no lock held; contention resolved round-robin
    // LOCK1 | master 1 holds the port while burst count is below the limit
    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_gnt;
    logic [7:0] r_burst_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_gnt0;
    logic       w_gnt1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_cnt_nxt;
            if (w_gnt0) begin
                r_last_gnt <= 1'b0;
            end else if (w_gnt1) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = IDLE;
        w_cnt_nxt   = r_burst_cnt;

        if (reset) begin
            if (m0Req && m1Req) begin
                if (r_state == LOCK1) begin
                    // Lock holds until the burst limit, then master 0 is forced in.
                    if (r_burst_cnt < MAX_CNT) begin
                        w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = 1'b1;
                    end
                end else if (r_last_gnt) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = m0Req;
                w_gnt1 = m1Req;
            end
        end

        if (w_gnt1 && m1Lock) begin
            w_state_nxt = LOCK1;
        end

        if (w_state_nxt == IDLE) begin
            w_cnt_nxt = 8'd0;
        end else if ((r_state == LOCK1) && w_gnt1 && m0Req && (r_burst_cnt < MAX_CNT)) begin
            w_cnt_nxt = r_burst_cnt + 8'd1;
        end
    end

    assign m0Ack    = w_gnt0;
    assign m1Ack    = w_gnt1;
    assign ramAddr  = w_gnt1 ? m1Addr  : m0Addr;
    assign ramWData = w_gnt1 ? m1WData : m0WData;
    assign ramMask  = w_gnt1 ? m1Mask  : m0Mask;
    assign ramWe    = (w_gnt0 & m0We) | (w_gnt1 & m1We);
    assign m0RData  = ramRData;
    assign m1RData  = ramRData;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_gnt0;
    logic [31:0] r_stat_gnt1;
    logic [31:0] r_stat_stall0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_gnt0   <= 32'd0;
            r_stat_gnt1   <= 32'd0;
            r_stat_stall0 <= 32'd0;
        end else begin
            if (w_gnt0) begin
                r_stat_gnt0 <= r_stat_gnt0 + 32'd1;
            end
            if (w_gnt1) begin
                r_stat_gnt1 <= r_stat_gnt1 + 32'd1;
            end
            if (m0Req && !w_gnt0) begin
                r_stat_stall0 <= r_stat_stall0 + 32'd1;
            end
        end
    end

    assign statGnt0   = r_stat_gnt0;
    assign statGnt1   = r_stat_gnt1;
    assign statStall0 = r_stat_stall0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level reference model and a behavioural RAM.
module tb_data_bus_arbiter;

    localparam int MAXB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0Req, m0We, m1Req, m1We, m1Lock;
    logic [31:0] m0Addr, m0WData, m1Addr, m1WData;
    logic [3:0]  m0Mask, m1Mask;
    logic [31:0] m0RData, m1RData;
    logic        m0Ack, m1Ack;
    logic [31:0] ramAddr, ramWData, ramRData;
    logic [3:0]  ramMask;
    logic        ramWe;
`ifdef ARB_STATS_EN
    logic [31:0] statGnt0, statGnt1, statStall0;
`endif

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .m0Req(m0Req), .m0We(m0We), .m0Addr(m0Addr), .m0WData(m0WData), .m0Mask(m0Mask),
        .m0RData(m0RData), .m0Ack(m0Ack),
        .m1Req(m1Req), .m1We(m1We), .m1Addr(m1Addr), .m1WData(m1WData), .m1Mask(m1Mask),
        .m1RData(m1RData), .m1Ack(m1Ack), .m1Lock(m1Lock),
        .ramAddr(ramAddr), .ramWData(ramWData), .ramMask(ramMask), .ramWe(ramWe),
        .ramRData(ramRData)
`ifdef ARB_STATS_EN
        , .statGnt0(statGnt0), .statGnt1(statGnt1), .statStall0(statStall0)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM driven only by the DUT's RAM port, plus the model's own memory image.
    logic [31:0] ram     [0:63];
    logic [31:0] ref_mem [0:63];
    assign ramRData = ram[ramAddr[7:2]];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who last won a contention, whether master 1 holds a lock,
    // and how many locked grants master 1 has taken while master 0 was waiting.
    int mdl_last_winner;
    bit mdl_locked;
    int mdl_locked_run;
    int mdl_g0, mdl_g1, mdl_s0;

    logic s0, s1, s_we;
    logic [31:0] s_rd0, s_rd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_grant(output bit e0, output bit e1);
        e0 = 1'b0;
        e1 = 1'b0;
        if (reset) begin
            if (m0Req && m1Req) begin
                if (mdl_locked) begin
                    e1 = (mdl_locked_run < MAXB);
                    e0 = !e1;
                end else begin
                    e1 = (mdl_last_winner == 0);
                    e0 = !e1;
                end
            end else begin
                e0 = m0Req;
                e1 = m1Req;
            end
        end
    endfunction

    function automatic void model_update(input bit e0, input bit e1);
        bool_update(e0, e1);
    endfunction

    function automatic void bool_update(input bit e0, input bit e1);
        logic [31:0] a, d;
        logic [3:0]  m;
        if (!reset) begin
            mdl_last_winner = 1;
            mdl_locked      = 1'b0;
            mdl_locked_run  = 0;
            mdl_g0 = 0; mdl_g1 = 0; mdl_s0 = 0;
            return;
        end
        mdl_g0 += int'(e0);
        mdl_g1 += int'(e1);
        mdl_s0 += int'(m0Req && !e0);
        if (e0 || e1) begin
            a = e1 ? m1Addr  : m0Addr;
            d = e1 ? m1WData : m0WData;
            m = e1 ? m1Mask  : m0Mask;
            if ((e1 && m1We) || (e0 && m0We)) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        if (e0) mdl_last_winner = 0;
        if (e1) mdl_last_winner = 1;
        if (mdl_locked && e1 && m0Req) mdl_locked_run = (mdl_locked_run < MAXB) ? mdl_locked_run + 1 : MAXB;
        mdl_locked = e1 && m1Lock;
        if (!mdl_locked) mdl_locked_run = 0;
    endfunction

    task automatic step();
        bit e0, e1;
        logic        c_we;
        logic [31:0] c_a, c_d;
        logic [3:0]  c_m;
        #2;
        model_grant(e0, e1);
        check_eq("m0Ack", 32'(m0Ack), 32'(e0));
        check_eq("m1Ack", 32'(m1Ack), 32'(e1));
        check_eq("ramWe", 32'(ramWe), 32'((e0 & m0We) | (e1 & m1We)));
        check_eq("ramAddr", ramAddr, e1 ? m1Addr : m0Addr);
        if (e0 && !m0We) check_eq("m0RData", m0RData, ref_mem[m0Addr[7:2]]);
        if (e1 && !m1We) check_eq("m1RData", m1RData, ref_mem[m1Addr[7:2]]);
        s0 = m0Ack; s1 = m1Ack; s_we = ramWe; s_rd0 = m0RData; s_rd1 = m1RData;
        c_we = ramWe; c_a = ramAddr; c_d = ramWData; c_m = ramMask;
        @(posedge clk);
        if (c_we) begin
            for (int b = 0; b < 4; b++)
                if (c_m[b]) ram[c_a[7:2]][8*b +: 8] = c_d[8*b +: 8];
        end
        model_update(e0, e1);
        #1;
    endtask

    task automatic idle_inputs();
        m0Req = 0; m0We = 0; m0Addr = 0; m0WData = 0; m0Mask = 0;
        m1Req = 0; m1We = 0; m1Addr = 0; m1WData = 0; m1Mask = 0; m1Lock = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        mdl_last_winner = 1; mdl_locked = 0; mdl_locked_run = 0;
        mdl_g0 = 0; mdl_g1 = 0; mdl_s0 = 0;
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();
        step();
        check_eq("rst_idle_ack0", 32'(s0), 32'd0);
        check_eq("rst_idle_we", 32'(s_we), 32'd0);

        // Uncontended write then read-back
        m0Req = 1; m0We = 1; m0Addr = 32'h10; m0WData = 32'hDEADBEEF; m0Mask = 4'hF;
        step();
        check_eq("t1_ack", 32'(s0), 32'd1);
        check_eq("t1_we", 32'(s_we), 32'd1);
        m0We = 0;
        step();
        check_eq("t1_rd", s_rd0, 32'hDEADBEEF);

        // Round-robin alternation from reset
        do_reset();
        m0Req = 1; m0We = 0; m0Addr = 32'h10;
        m1Req = 1; m1We = 0; m1Addr = 32'h14; m1Lock = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr_ack0", 32'(s0), 32'(i % 2 == 0));
            check_eq("rr_ack1", 32'(s1), 32'(i % 2 == 1));
        end
`ifdef ARB_STATS_EN
        check_eq("stat_gnt0", statGnt0, 32'd2);
        check_eq("stat_gnt1", statGnt1, 32'd2);
        check_eq("stat_stall0", statStall0, 32'd2);
`endif

        // Lone locked burst, then master 0 contends
        do_reset();
        m1Req = 1; m1Lock = 1; m1We = 1; m1Addr = 32'h30; m1WData = 32'h1234_5678; m1Mask = 4'hF;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("lone_ack1", 32'(s1), 32'd1);
        end
        m0Req = 1; m0We = 0; m0Addr = 32'h30;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("burst_ack1", 32'(s1), 32'(i != 8));
            check_eq("burst_ack0", 32'(s0), 32'(i == 8));
        end

        // Reset pulse during a locked master-1 write
        m0Req = 0;
        m1Addr = 32'h38; m1WData = 32'hCAFE_F00D;
        reset = 1'b0;
        step();
        check_eq("rstmid_ack1", 32'(s1), 32'd0);
        check_eq("rstmid_we", 32'(s_we), 32'd0);
        reset = 1'b1;
        m1We = 0; m0Req = 1; m0We = 0; m0Addr = 32'h38;
        step();
        check_eq("rstmid_first0", 32'(s0), 32'd1);
        check_eq("rstmid_nowrite", s_rd0, 32'd0);

        // Randomized traffic; masters hold their request until acked
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!m0Req || s0) begin
                m0Req = ($urandom_range(0, 3) != 0);
                m0We = $urandom_range(0, 1) == 1;
                m0Addr = 32'($urandom_range(0, 15)) << 2;
                m0WData = $urandom;
                m0Mask = 4'($urandom);
            end
            if (!m1Req || s1) begin
                m1Req = ($urandom_range(0, 3) != 0);
                m1We = $urandom_range(0, 1) == 1;
                m1Addr = 32'($urandom_range(0, 15)) << 2;
                m1WData = $urandom;
                m1Mask = 4'($urandom);
            end
            m1Lock = ($urandom_range(0, 9) < 8);
            reset = ($urandom_range(0, 149) != 0);
            step();
            if (!reset) begin
                s0 = 1'b0;
                s1 = 1'b0;
            end
        end
        reset = 1'b1;
        idle_inputs();
        step();
`ifdef ARB_STATS_EN
        check_eq("stat_rand_gnt0", statGnt0, 32'(mdl_g0));
        check_eq("stat_rand_gnt1", statGnt1, 32'(mdl_g1));
        check_eq("stat_rand_stall0", statStall0, 32'(mdl_s0));
`endif
        for (int i = 0; i < 16; i++) begin
            check_eq("ram_image", ram[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
